// File: rtl/fir_param_pkg.sv
// Shared types and helpers for the parametrised FIR engine.
// States, accumulator sizing and output saturation.
package fir_param_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    OUT
  } state_t;

  localparam int SAT_W = 64;

  function automatic int acc_width(
    input int dw,
    input int nt
  );
    return 2 * dw + $clog2(nt);
  endfunction

  // Clamp a wide signed value into dw-bit two's complement range.
  function automatic logic signed [SAT_W-1:0] saturate(
    input  logic signed [SAT_W-1:0] r,
    input  int                      dw,
    output logic                    ovf
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    ovf = 1'b0;
    saturate = r;
    if (r > hi) begin
      ovf      = 1'b1;
      saturate = hi;
    end else if (r < lo) begin
      ovf      = 1'b1;
      saturate = lo;
    end
  endfunction

endpackage

// File: rtl/fir_sample_counter.sv
// Counts completed filter outputs, saturating at SAMPLE_COUNT.
// done is a level that holds until the next clear.
module fir_sample_counter #(
  parameter int SAMPLE_COUNT = 1000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic incr,
  output logic done
);

  localparam int CW = $clog2(SAMPLE_COUNT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(SAMPLE_COUNT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (incr && cnt != LIMIT) begin
      cnt  <= cnt_inc;
      done <= (cnt_inc == LIMIT);
    end
  end

endmodule

// File: rtl/sync_low.sv
// Two-flop synchroniser for an asynchronous level input.
// Both stages reset low.
module sync_low (
  input  logic clk,
  input  logic n_reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/fir_filter_param.sv
// N-tap Q1.(DATA_W-1) FIR engine, one tap MAC per cycle.
// Serial coefficient load, saturated output, sticky error.
module fir_filter_param
  import fir_param_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int NTAPS        = 4,
  parameter int SAMPLE_COUNT = 1000
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] fir_coefficient,
  input  logic              load_coeff,
  input  logic              data_ready,
  output logic [DATA_W-1:0] fir_out,
  output logic              modwait,
  output logic              err,
  output logic              count_done
);

  localparam int ACC_W = acc_width(DATA_W, NTAPS);
  localparam int PRD_W = 2 * DATA_W;
  localparam int TAP_W = $clog2(NTAPS);
  localparam logic [TAP_W-1:0] LAST = TAP_W'(NTAPS - 1);

  state_t state;
  state_t state_nx;

  logic dr_sync;
  logic lc_sync;
  logic dr_q;
  logic lc_q;
  logic dr_edge;
  logic lc_edge;

  logic signed [DATA_W-1:0] smp  [NTAPS];
  logic signed [DATA_W-1:0] coef [NTAPS];

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [PRD_W-1:0] prod;
  logic signed [SAT_W-1:0] sat_val;
  logic                    sat_ovf;

  logic [TAP_W-1:0] tap;
  logic [TAP_W-1:0] load_idx;

  sync_low u_sync_dr (
    .clk      (clk),
    .n_reset  (n_reset),
    .async_in (data_ready),
    .sync_out (dr_sync)
  );

  sync_low u_sync_lc (
    .clk      (clk),
    .n_reset  (n_reset),
    .async_in (load_coeff),
    .sync_out (lc_sync)
  );

  assign dr_edge = dr_sync & ~dr_q;
  assign lc_edge = lc_sync & ~lc_q;
  assign modwait = (state != IDLE);

  always_comb begin
    prod = PRD_W'(smp[tap]) * PRD_W'(coef[tap]);
    acc_sh = acc >>> (DATA_W - 1);
    sat_ovf = 1'b0;
    sat_val = saturate(SAT_W'(acc_sh), DATA_W, sat_ovf);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (lc_edge)      state_nx = LOAD;
        else if (dr_edge) state_nx = MAC;
      end
      LOAD:    state_nx = IDLE;
      MAC:     if (tap == LAST) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      dr_q     <= 1'b0;
      lc_q     <= 1'b0;
      acc      <= '0;
      tap      <= '0;
      load_idx <= '0;
      fir_out  <= '0;
      err      <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        smp[k]  <= '0;
        coef[k] <= '0;
      end
    end else begin
      dr_q <= dr_sync;
      lc_q <= lc_sync;
      // Any request arriving while busy is discarded.
      if (state != IDLE && (dr_edge || lc_edge))
        err <= 1'b1;
      case (state)
        IDLE: begin
          if (lc_edge) begin
            coef[load_idx] <= fir_coefficient;
            load_idx <= (load_idx == LAST) ?
                        '0 : load_idx + 1'b1;
            if (dr_edge) err <= 1'b1;
          end else if (dr_edge) begin
            for (int k = NTAPS - 1; k > 0; k--)
              smp[k] <= smp[k-1];
            smp[0] <= sample_data;
            acc    <= '0;
            tap    <= '0;
            err    <= 1'b0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          tap <= tap + 1'b1;
        end
        OUT: begin
          fir_out <= DATA_W'(sat_val);
          if (sat_ovf) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  fir_sample_counter #(
    .SAMPLE_COUNT (SAMPLE_COUNT)
  ) u_cnt (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   ((state == IDLE) && lc_edge),
    .incr    (state == OUT),
    .done    (count_done)
  );

endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench for fir_filter_param.
// Table vectors plus hand sequences, scoreboard queue.
module tb_fir_filter_param;

  localparam int NTAPS = 4;

  typedef struct packed {
    logic [15:0] smp;
    logic [15:0] eo;
    logic        ee;
    logic        ed;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] sample_data;
  logic [15:0] fir_coefficient;
  logic        load_coeff;
  logic        data_ready;
  logic [15:0] fir_out;
  logic        modwait;
  logic        err;
  logic        count_done;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t sb[$];
  vec_t tbl[9];
  vec_t sat[5];

  always #5 clk = ~clk;

  fir_filter_param #(
    .DATA_W       (16),
    .NTAPS        (NTAPS),
    .SAMPLE_COUNT (8)
  ) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .sample_data     (sample_data),
    .fir_coefficient (fir_coefficient),
    .load_coeff      (load_coeff),
    .data_ready      (data_ready),
    .fir_out         (fir_out),
    .modwait         (modwait),
    .err             (err),
    .count_done      (count_done)
  );

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Count busy cycles after a request; bounded.
  task automatic wait_busy(
    input  bit glitch,
    output int hi
  );
    bit seen;
    bit fin;
    seen = 1'b0;
    fin  = 1'b0;
    hi   = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      if (glitch && i == 2) data_ready = 1'b0;
      if (glitch && i == 3) data_ready = 1'b1;
      if (modwait) begin
        hi++;
        seen = 1'b1;
      end else if (seen) begin
        fin = 1'b1;
      end
    end
    check("busy_end", {31'd0, fin}, 1);
  endtask

  task automatic settle();
    data_ready = 1'b0;
    load_coeff = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] d);
    int hi;
    @(negedge clk);
    fir_coefficient = d;
    load_coeff = 1'b1;
    wait_busy(1'b0, hi);
    check("load_modwait", hi, 1);
    settle();
  endtask

  task automatic send_sample(
    input logic [15:0] d,
    input logic [15:0] eo,
    input logic        ee,
    input logic        ed,
    input bit          glitch
  );
    vec_t v;
    int hi;
    v = '{d, eo, ee, ed};
    sb.push_back(v);
    @(negedge clk);
    sample_data = d;
    data_ready = 1'b1;
    wait_busy(glitch, hi);
    check($sformatf("modwait_cyc[%h]", d), hi, NTAPS + 1);
    v = sb.pop_front();
    check($sformatf("fir_out[%h]", v.smp), fir_out, v.eo);
    check($sformatf("err[%h]", v.smp), err, v.ee);
    check($sformatf("done[%h]", v.smp), count_done, v.ed);
    if (!glitch) settle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hi;
    tbl[0] = '{16'h1000, 16'h0800, 1'b0, 1'b0};
    tbl[1] = '{16'h2000, 16'h1800, 1'b0, 1'b0};
    tbl[2] = '{16'h0000, 16'h1000, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'hC000, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0};
    tbl[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[6] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    tbl[7] = '{16'h0400, 16'h41FF, 1'b0, 1'b1};
    tbl[8] = '{16'h0000, 16'h0200, 1'b0, 1'b1};
    sat[0] = '{16'h7FFF, 16'h7FFE, 1'b0, 1'b0};
    sat[1] = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b0};
    sat[2] = '{16'h8000, 16'h7FFD, 1'b0, 1'b0};
    sat[3] = '{16'h8000, 16'hFFFE, 1'b0, 1'b0};
    sat[4] = '{16'h8000, 16'h8000, 1'b1, 1'b0};

    n_reset = 1'b0;
    sample_data = '0;
    fir_coefficient = '0;
    load_coeff = 1'b0;
    data_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_fir_out", fir_out, 0);
    check("rst_modwait", modwait, 0);
    check("rst_err", err, 0);
    check("rst_done", count_done, 0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic table: two-tap half/half filter.
    load(16'h4000);
    load(16'h4000);
    load(16'h0000);
    load(16'h0000);
    foreach (tbl[i])
      send_sample(tbl[i].smp, tbl[i].eo,
                  tbl[i].ee, tbl[i].ed, 1'b0);

    load(16'h4000);
    check("done_cleared", count_done, 0);
    for (int i = 0; i < 8; i++)
      send_sample(16'h0000, 16'h0000, 1'b0,
                  (i == 7), 1'b0);

    // Reset in the middle of a MAC run.
    @(negedge clk);
    sample_data = 16'h1234;
    data_ready = 1'b1;
    for (int i = 0; i < 10 && !modwait; i++)
      @(negedge clk);
    check("mac_started", modwait, 1);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("midrst_fir_out", fir_out, 0);
    check("midrst_modwait", modwait, 0);
    check("midrst_err", err, 0);
    check("midrst_done", count_done, 0);
    data_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);

    // Zeroed delay line, negative sample.
    repeat (4) load(16'h4000);
    send_sample(16'h8000, 16'hC000, 1'b0, 1'b0, 1'b0);

    do_reset();
    repeat (4) load(16'h7FFF);
    foreach (sat[i])
      send_sample(sat[i].smp, sat[i].eo,
                  sat[i].ee, sat[i].ed, 1'b0);

    // Second data_ready edge lands during MAC.
    do_reset();
    load(16'h4000);
    load(16'h4000);
    load(16'h0000);
    load(16'h0000);
    send_sample(16'h2000, 16'h1000, 1'b1, 1'b0, 1'b1);
    data_ready = 1'b0;
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (modwait) hi++;
    end
    check("dropped_stays_idle", hi, 0);

    // Simultaneous edges: load wins, sample dropped.
    @(negedge clk);
    fir_coefficient = 16'h2000;
    sample_data = 16'h7000;
    load_coeff = 1'b1;
    data_ready = 1'b1;
    wait_busy(1'b0, hi);
    check("simul_modwait", hi, 1);
    check("simul_err", err, 1);
    check("simul_fir_out", fir_out, 16'h1000);
    settle();
    send_sample(16'h4000, 16'h2000, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
